// File: rtl/apb_timer_mc_if.sv
// apb_timer_mc_if: APB bus bundle shared by the multi-channel timer and its bus master.
// ADDR_W must match the ADDR_W of the attached apb_timer_mc.
interface apb_timer_mc_if #(
   parameter int ADDR_W = 8
) ();
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [31:0]       pwdata;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_timer_mc.sv
// apb_timer_mc: NUM_CH independent WIDTH-bit up/down timers behind one zero-wait APB slave.
// Optional auto-reload on wrap (TCR[3]) is enabled by defining TIMER_AUTORELOAD_EN.
module apb_timer_mc #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 8
) (
   input  logic              pclk,
   input  logic              prst,
   apb_timer_mc_if.slave     bus,
   output logic [NUM_CH-1:0] irq,
   output logic              irq_any
);
   localparam int CH_W = ADDR_W - 4;
`ifdef TIMER_AUTORELOAD_EN
   localparam logic [7:0] TCR_MASK = 8'hFF;
`else
   localparam logic [7:0] TCR_MASK = 8'hF7;
`endif
   localparam logic [1:0] OFF_TDR  = 2'd0;
   localparam logic [1:0] OFF_TCR  = 2'd1;
   localparam logic [1:0] OFF_TSR  = 2'd2;
   localparam logic [1:0] OFF_TCNT = 2'd3;

   logic [WIDTH-1:0] tdr      [NUM_CH];
   logic [7:0]       tcr      [NUM_CH];
   logic [1:0]       tsr      [NUM_CH];
   logic [WIDTH-1:0] tcnt     [NUM_CH];
   logic [7:0]       div      [NUM_CH];
   logic [WIDTH-1:0] cnt_next [NUM_CH];

   logic [CH_W-1:0]   ch_idx;
   logic [31:0]       ch_num;
   logic [1:0]        off;
   logic              access;
   logic              ch_ok;
   logic              err;
   logic              wr_ok;
   logic [31:0]       rdata;
   logic [NUM_CH-1:0] wr_tdr;
   logic [NUM_CH-1:0] wr_tcr;
   logic [NUM_CH-1:0] wr_tsr;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] set_ovf;
   logic [NUM_CH-1:0] set_udf;
   logic              unused_bits;

   assign ch_idx      = bus.paddr[ADDR_W-1:4];
   assign off         = bus.paddr[3:2];
   assign ch_num      = 32'(ch_idx);
   assign access      = !prst && bus.psel && bus.penable;
   assign ch_ok       = ch_num < 32'(NUM_CH);
   assign err         = !ch_ok || (bus.pwrite && off == OFF_TCNT);
   assign wr_ok       = access && bus.pwrite && !err;
   assign bus.pready  = 1'b1;
   assign bus.pslverr = access && err;
   assign bus.prdata  = rdata;
   assign unused_bits = ^{bus.paddr[1:0], bus.pwdata};

   always_comb begin
      wr_tdr = '0;
      wr_tcr = '0;
      wr_tsr = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (wr_ok && ch_num == c) begin
            wr_tdr[c] = (off == OFF_TDR);
            wr_tcr[c] = (off == OFF_TCR);
            wr_tsr[c] = (off == OFF_TSR);
         end
      end
   end

   // Terminal divider count is 2^(clk_sel+1)-1; a TCR write in the same cycle suppresses the tick.
   always_comb begin
      tick    = '0;
      set_ovf = '0;
      set_udf = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         cnt_next[c] = tcnt[c];
         tick[c]     = tcr[c][4] && !tcr[c][7] && !wr_tcr[c] &&
                       (div[c] == 8'((9'd2 << tcr[c][2:0]) - 9'd1));
         set_ovf[c]  = tick[c] && !tcr[c][5] && (tcnt[c] == '1);
         set_udf[c]  = tick[c] &&  tcr[c][5] && (tcnt[c] == '0);
         if (tcr[c][5])
            cnt_next[c] = tcnt[c] - WIDTH'(1);
         else
            cnt_next[c] = tcnt[c] + WIDTH'(1);
`ifdef TIMER_AUTORELOAD_EN
         if ((set_ovf[c] || set_udf[c]) && tcr[c][3])
            cnt_next[c] = tdr[c];
`endif
      end
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            tdr[c]  <= '0;
            tcr[c]  <= '0;
            tsr[c]  <= '0;
            tcnt[c] <= '0;
            div[c]  <= '0;
         end
         irq <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (wr_tdr[c])
               tdr[c] <= bus.pwdata[WIDTH-1:0];
            if (wr_tcr[c])
               tcr[c] <= bus.pwdata[7:0] & TCR_MASK;

            if (wr_tcr[c] || !tcr[c][4] || tcr[c][7] || tick[c])
               div[c] <= '0;
            else
               div[c] <= div[c] + 8'd1;

            if (tcr[c][7])
               tcnt[c] <= tdr[c];
            else if (tick[c])
               tcnt[c] <= cnt_next[c];

            // Hardware set is ORed in after the write-0-to-clear mask, so a same-cycle set wins.
            if (wr_tsr[c])
               tsr[c] <= {set_udf[c], set_ovf[c]} | (tsr[c] & bus.pwdata[1:0]);
            else
               tsr[c] <= tsr[c] | {set_udf[c], set_ovf[c]};

            irq[c] <= tcr[c][6] && (tsr[c] != 2'b00);
         end
      end
   end

   assign irq_any = |irq;

   always_comb begin
      rdata = '0;
      if (access && !bus.pwrite && ch_ok) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_num == c) begin
               case (off)
                  OFF_TDR:  rdata[WIDTH-1:0] = tdr[c];
                  OFF_TCR:  rdata[7:0]       = tcr[c];
                  OFF_TSR:  rdata[1:0]       = tsr[c];
                  default:  rdata[WIDTH-1:0] = tcnt[c];
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_apb_timer_mc.sv
// tb_apb_timer_mc: directed scoreboard bench for apb_timer_mc (NUM_CH=4, WIDTH=8).
`timescale 1ns/1ps
module tb_apb_timer_mc;
   localparam int NUM_CH = 4;
   localparam int WIDTH  = 8;
   localparam int ADDR_W = 8;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic              pclk = 1'b0;
   logic              prst = 1'b1;
   logic [NUM_CH-1:0] irq;
   logic              irq_any;
   int unsigned       cyc = 0;
   int                n_checks = 0;
   int                n_fail = 0;
   exp_t              sb[$];
   int unsigned       w0, w1, w2, wt, wc, wa;

   apb_timer_mc_if #(.ADDR_W(ADDR_W)) bus ();

   apb_timer_mc #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .pclk    (pclk),
      .prst    (prst),
      .bus     (bus),
      .irq     (irq),
      .irq_any (irq_any)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_sig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      exp_t e;
      e.tag = tag; e.data = exp; e.err = 1'b0;
      sb.push_back(e);
      e = sb.pop_front();
      check(e.tag, obs, e.data);
   endtask

   // Called just after an edge E: setup in E..E+1, access in E+1..E+2, returns at E+2 (+1ns).
   task automatic apb_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic exp_err, input string tag);
      exp_t e;
      e.tag = tag; e.data = 32'h0; e.err = exp_err;
      sb.push_back(e);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = d;
      @(posedge pclk); #1;
      bus.penable = 1'b1;
      #3;
      e = sb.pop_front();
      check({e.tag, ".err"}, 32'(bus.pslverr), 32'(e.err));
      check({e.tag, ".rd0"}, bus.prdata, e.data);
      @(posedge pclk); #1;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp_d,
                           input logic exp_err, input string tag);
      exp_t e;
      e.tag = tag; e.data = exp_d; e.err = exp_err;
      sb.push_back(e);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
      @(posedge pclk); #1;
      bus.penable = 1'b1;
      #3;
      e = sb.pop_front();
      check({e.tag, ".data"}, bus.prdata, e.data);
      check({e.tag, ".err"}, 32'(bus.pslverr), 32'(e.err));
      @(posedge pclk); #1;
      bus.psel = 1'b0; bus.penable = 1'b0;
   endtask

   task automatic wait_cyc(input int unsigned t);
      while (cyc < t) begin
         @(posedge pclk); #1;
      end
   endtask

   // Places the access phase of the read in the cycle that starts at edge t.
   task automatic read_at(input int unsigned t, input logic [ADDR_W-1:0] a,
                          input logic [31:0] exp_d, input string tag);
      wait_cyc(t - 1);
      apb_read(a, exp_d, 1'b0, tag);
   endtask

   initial begin
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = '0; bus.pwdata = '0;
      prst = 1'b1;
      repeat (3) @(posedge pclk);
      #1 prst = 1'b0;

      expect_sig("rst.irq",     32'(irq),         32'h0);
      expect_sig("rst.irq_any", 32'(irq_any),     32'h0);
      expect_sig("rst.prdata",  bus.prdata,       32'h0);
      expect_sig("rst.pslverr", 32'(bus.pslverr), 32'h0);
      expect_sig("rst.pready",  32'(bus.pready),  32'h1);

      // Legacy: ch0 counts down from 0xFF at /16
      apb_write(8'h00, 32'hFF, 1'b0, "leg.tdr");
      apb_write(8'h04, 32'h80, 1'b0, "leg.load");
      apb_write(8'h04, 32'h33, 1'b0, "leg.start");
      w0 = cyc;
      apb_read(8'h04, 32'h33, 1'b0, "leg.tcr");
      read_at(w0 + 16*220,     8'h08, 32'h00, "leg.tsr220");
      read_at(w0 + 16*220 + 4, 8'h0C, 32'h23, "leg.tcnt220");
      read_at(w0 + 16*256,     8'h08, 32'h02, "leg.tsr256");
      read_at(w0 + 16*256 + 4, 8'h0C, 32'hFF, "leg.tcnt256");
      expect_sig("leg.irq0", 32'(irq[0]), 32'h0);
      apb_write(8'h08, 32'h00, 1'b0, "leg.clr");
      apb_read(8'h08, 32'h00, 1'b0, "leg.tsrclr");

      // Overflow: ch1 up at /2 from 0xFE
      apb_write(8'h10, 32'hFE, 1'b0, "ovf.tdr");
      apb_write(8'h14, 32'h80, 1'b0, "ovf.load");
      apb_write(8'h14, 32'h10, 1'b0, "ovf.start");
      w1 = cyc;
      read_at(w1 + 2, 8'h1C, 32'hFF, "ovf.tcnt2");
      read_at(w1 + 4, 8'h1C, 32'h00, "ovf.tcnt4");
      read_at(w1 + 6, 8'h18, 32'h01, "ovf.tsr");
      expect_sig("ovf.irq1", 32'(irq[1]), 32'h0);

      // Interrupts: ch2 with ie, ch3 without, both down from 0
      apb_write(8'h20, 32'h00, 1'b0, "int.tdr2");
      apb_write(8'h30, 32'h00, 1'b0, "int.tdr3");
      apb_write(8'h24, 32'h80, 1'b0, "int.load2");
      apb_write(8'h34, 32'h80, 1'b0, "int.load3");
      apb_write(8'h34, 32'h30, 1'b0, "int.start3");
      apb_write(8'h24, 32'h70, 1'b0, "int.start2");
      w2 = cyc;
      wait_cyc(w2 + 2);
      expect_sig("int.irq2_early", 32'(irq[2]), 32'h0);
      wait_cyc(w2 + 3);
      expect_sig("int.irq2",    32'(irq[2]),  32'h1);
      expect_sig("int.irq3",    32'(irq[3]),  32'h0);
      expect_sig("int.irq_any", 32'(irq_any), 32'h1);
      apb_write(8'h28, 32'h00, 1'b0, "int.clr2");
      wt = cyc;
      expect_sig("int.irq2_hold", 32'(irq[2]), 32'h1);
      wait_cyc(wt + 1);
      expect_sig("int.irq2_clr",    32'(irq[2]),  32'h0);
      expect_sig("int.irq_any_clr", 32'(irq_any), 32'h0);
      apb_read(8'h28, 32'h00, 1'b0, "int.tsr2");

      // Collision: TSR clear commits on the edge that sets udf on ch3
      apb_write(8'h34, 32'h80, 1'b0, "col.load");
      apb_write(8'h38, 32'h00, 1'b0, "col.preclr");
      apb_read(8'h38, 32'h00, 1'b0, "col.tsr0");
      apb_write(8'h34, 32'h30, 1'b0, "col.start");
      wc = cyc;
      apb_write(8'h38, 32'h00, 1'b0, "col.clr");
      check("col.align", 32'(cyc), 32'(wc + 2));
      apb_read(8'h38, 32'h02, 1'b0, "col.tsr");

      // Errors
      apb_read(8'h40, 32'h00, 1'b1, "err.oor_rd");
      apb_write(8'h40, 32'h55, 1'b1, "err.oor_wr");
      apb_write(8'h14, 32'h00, 1'b0, "err.stop1");
      apb_write(8'h10, 32'h5A, 1'b0, "err.tdr1");
      apb_write(8'h14, 32'h80, 1'b0, "err.load1");
      apb_write(8'h14, 32'h00, 1'b0, "err.hold1");
      apb_write(8'h1C, 32'h11, 1'b1, "err.tcnt_wr");
      apb_read(8'h1C, 32'h5A, 1'b0, "err.tcnt");

`ifdef TIMER_AUTORELOAD_EN
      // Auto-reload: ch1 down from 5 with ar=1
      apb_write(8'h10, 32'h05, 1'b0, "ar.tdr");
      apb_write(8'h14, 32'h80, 1'b0, "ar.load");
      apb_write(8'h18, 32'h00, 1'b0, "ar.clr");
      apb_write(8'h14, 32'h38, 1'b0, "ar.start");
      wa = cyc;
      apb_read(8'h14, 32'h38, 1'b0, "ar.tcr");
      read_at(wa + 10, 8'h1C, 32'h00, "ar.tcnt5");
      read_at(wa + 12, 8'h1C, 32'h05, "ar.tcnt6");
      apb_read(8'h18, 32'h02, 1'b0, "ar.tsr");
`else
      apb_write(8'h14, 32'h08, 1'b0, "ar.rsvd_wr");
      apb_read(8'h14, 32'h00, 1'b0, "ar.rsvd_rd");
      apb_write(8'h14, 32'h1B, 1'b0, "ar.rsvd_mix");
      apb_read(8'h14, 32'h13, 1'b0, "ar.rsvd_rd2");
`endif

      // Reset mid-count, with APB traffic during reset
      apb_write(8'h24, 32'h70, 1'b0, "rst.run2");
      prst = 1'b1;
      apb_write(8'h00, 32'hAA, 1'b0, "rst.wr");
      apb_read(8'h04, 32'h00, 1'b0, "rst.rd");
      prst = 1'b0;
      expect_sig("rst2.irq",     32'(irq),     32'h0);
      expect_sig("rst2.irq_any", 32'(irq_any), 32'h0);
      for (int c = 0; c < NUM_CH; c++) begin
         for (int r = 0; r < 4; r++) begin
            apb_read(ADDR_W'(c*16 + r*4), 32'h00, 1'b0, $sformatf("rst2.ch%0d.r%0d", c, r));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
